// File: rtl/decompose_l1.sv
// Level-1 sym4 low-pass decomposition with decimation by 2 in FP32.
// Input reg, multiply, three adder levels and output reg give a fixed 6-cycle latency.
module decompose_l1 #(
  parameter logic [31:0] DEC_H0 = 32'hbd9b2b0e,
  parameter logic [31:0] DEC_H1 = 32'hbcf2c635,
  parameter logic [31:0] DEC_H2 = 32'h3efec7e0,
  parameter logic [31:0] DEC_H3 = 32'h3f4dc1d3,
  parameter logic [31:0] DEC_H4 = 32'h3e9880d1,
  parameter logic [31:0] DEC_H5 = 32'hbdcb339e,
  parameter logic [31:0] DEC_H6 = 32'hbc4e80df,
  parameter logic [31:0] DEC_H7 = 32'h3d03fc5f
) (
  input  logic        clk_78_125,
  input  logic        rstn,
  input  logic        din_valid,
  input  logic [31:0] din_0,  input logic [31:0] din_1,  input logic [31:0] din_2,
  input  logic [31:0] din_3,  input logic [31:0] din_4,  input logic [31:0] din_5,
  input  logic [31:0] din_6,  input logic [31:0] din_7,  input logic [31:0] din_8,
  input  logic [31:0] din_9,  input logic [31:0] din_10, input logic [31:0] din_11,
  input  logic [31:0] din_12, input logic [31:0] din_13, input logic [31:0] din_14,
  input  logic [31:0] din_15,
  output logic        dout_valid,
  output logic [31:0] a1_0, output logic [31:0] a1_1, output logic [31:0] a1_2,
  output logic [31:0] a1_3, output logic [31:0] a1_4, output logic [31:0] a1_5,
  output logic [31:0] a1_6, output logic [31:0] a1_7
);

  localparam logic [31:0] QNaN = 32'h7fc00000;
  localparam logic [31:0] Taps [8] = '{DEC_H0, DEC_H1, DEC_H2, DEC_H3,
                                       DEC_H4, DEC_H5, DEC_H6, DEC_H7};

  // Round-to-nearest-even on a normalised 1.m significand; underflow flushes to +0.
  function automatic logic [31:0] fp_round(logic s, logic signed [9:0] e, logic [22:0] m,
                                           logic g, logic st);
    logic [23:0]       mr;
    logic signed [9:0] er;
    mr = {1'b0, m} + {23'd0, g & (st | m[0])};
    er = mr[23] ? e + 10'sd1 : e;
    if (er >= 10'sd255) return {s, 8'hff, 23'd0};
    if (er <= 10'sd0) return 32'h0;
    return {s, er[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(logic [31:0] a, logic [31:0] b);
    logic              za, zb, ia, ib, s;
    logic [47:0]       p;
    logic signed [9:0] e;
    za = (a[30:23] == 8'd0);
    zb = (b[30:23] == 8'd0);
    ia = (a[30:23] == 8'hff);
    ib = (b[30:23] == 8'hff);
    if ((ia && a[22:0] != 23'd0) || (ib && b[22:0] != 23'd0) || (ia && zb) || (ib && za))
      return QNaN;
    s = a[31] ^ b[31];
    if (ia || ib) return {s, 8'hff, 23'd0};
    // Flushed subnormals count as +0 when forming the sign of a zero product.
    if (za || zb) return {(za ? 1'b0 : a[31]) ^ (zb ? 1'b0 : b[31]), 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) return fp_round(s, e + 10'sd1, p[46:24], p[23], |p[22:0]);
    return fp_round(s, e, p[45:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(logic [31:0] a, logic [31:0] b);
    logic [31:0]       af, bf, x, y;
    logic [26:0]       mx, my, sh, n;
    logic [27:0]       sum;
    logic [7:0]        d;
    logic              st;
    logic signed [9:0] e;
    if ((a[30:23] == 8'hff && a[22:0] != 23'd0) || (b[30:23] == 8'hff && b[22:0] != 23'd0) ||
        (a[30:23] == 8'hff && b[30:23] == 8'hff && a[31] != b[31]))
      return QNaN;
    if (a[30:23] == 8'hff) return a;
    if (b[30:23] == 8'hff) return b;
    af = (a[30:23] == 8'd0) ? 32'h0 : a;
    bf = (b[30:23] == 8'd0) ? 32'h0 : b;
    if (af[30:0] == 31'd0 && bf[30:0] == 31'd0) return {af[31] & bf[31], 31'd0};
    if (af[30:0] == 31'd0) return bf;
    if (bf[30:0] == 31'd0) return af;
    x  = (af[30:0] < bf[30:0]) ? bf : af;
    y  = (af[30:0] < bf[30:0]) ? af : bf;
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    st = 1'b0;
    for (int i = 0; i < 27; i++) if (i < int'(d)) st = st | my[i];
    sh = (d > 8'd26) ? 27'd0 : (my >> d);
    sh[0] = sh[0] | st;
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, sh};
      if (sum[27]) begin
        n = {sum[27:2], sum[1] | sum[0]};
        e = e + 10'sd1;
      end else begin
        n = sum[26:0];
      end
    end else begin
      n = mx - sh;
      if (n == 27'd0) return 32'h0;
      for (int i = 0; i < 26; i++) begin
        if (!n[26]) begin
          n = n << 1;
          e = e - 10'sd1;
        end
      end
    end
    return fp_round(x[31], e, n[25:3], n[2], |n[1:0]);
  endfunction

  logic [31:0] din_w [16];
  assign din_w = '{din_0, din_1, din_2,  din_3,  din_4,  din_5,  din_6,  din_7,
                   din_8, din_9, din_10, din_11, din_12, din_13, din_14, din_15};

  // Window holds 6 history samples (x[-6..-1]) followed by the 16 samples of the beat.
  logic [31:0] hist_q [6],    hist_d [6];
  logic [31:0] win_q  [22],   win_d  [22];
  logic [31:0] prod_q [8][8], prod_d [8][8];
  logic [31:0] s1_q   [8][4], s1_d   [8][4];
  logic [31:0] s2_q   [8][2], s2_d   [8][2];
  logic [31:0] s3_q   [8],    s3_d   [8];
  logic [31:0] a1_q   [8],    a1_d   [8];
  logic [5:0]  vld_q,         vld_d;

  always_comb begin
    hist_d = hist_q;
    if (din_valid) for (int i = 0; i < 6; i++) hist_d[i] = din_w[10 + i];
    for (int i = 0; i < 6; i++) win_d[i] = hist_q[i];
    for (int i = 0; i < 16; i++) win_d[6 + i] = din_w[i];
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) prod_d[k][j] = fp_mul(Taps[j], win_q[2 * k + 7 - j]);
      for (int i = 0; i < 4; i++) s1_d[k][i] = fp_add(prod_q[k][2 * i], prod_q[k][2 * i + 1]);
      for (int i = 0; i < 2; i++) s2_d[k][i] = fp_add(s1_q[k][2 * i], s1_q[k][2 * i + 1]);
      s3_d[k] = fp_add(s2_q[k][0], s2_q[k][1]);
    end
    a1_d = a1_q;
    if (vld_q[4]) a1_d = s3_q;
    vld_d = {vld_q[4:0], din_valid};
  end

  always_ff @(posedge clk_78_125 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 6; i++) hist_q[i] <= '0;
      for (int i = 0; i < 22; i++) win_q[i] <= '0;
      for (int k = 0; k < 8; k++) begin
        for (int j = 0; j < 8; j++) prod_q[k][j] <= '0;
        for (int i = 0; i < 4; i++) s1_q[k][i] <= '0;
        for (int i = 0; i < 2; i++) s2_q[k][i] <= '0;
        s3_q[k] <= '0;
        a1_q[k] <= '0;
      end
      vld_q <= '0;
    end else begin
      hist_q <= hist_d;
      win_q  <= win_d;
      prod_q <= prod_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      a1_q   <= a1_d;
      vld_q  <= vld_d;
    end
  end

  assign dout_valid = vld_q[5];
  assign a1_0 = a1_q[0];
  assign a1_1 = a1_q[1];
  assign a1_2 = a1_q[2];
  assign a1_3 = a1_q[3];
  assign a1_4 = a1_q[4];
  assign a1_5 = a1_q[5];
  assign a1_6 = a1_q[6];
  assign a1_7 = a1_q[7];

endmodule

// File: tb/tb_decompose_l1.sv
// Bench for decompose_l1: directed vector table, hand sequences and a real-arithmetic
// reference model fed by random beats.
module tb_decompose_l1;

  logic              clk_78_125 = 1'b0;
  logic              rstn       = 1'b0;
  logic              din_valid  = 1'b0;
  logic [15:0][31:0] din        = '0;
  logic              dout_valid;
  logic [7:0][31:0]  a1;

  always #5 clk_78_125 = ~clk_78_125;

  decompose_l1 dut (
    .clk_78_125(clk_78_125), .rstn(rstn), .din_valid(din_valid),
    .din_0(din[0]),   .din_1(din[1]),   .din_2(din[2]),   .din_3(din[3]),
    .din_4(din[4]),   .din_5(din[5]),   .din_6(din[6]),   .din_7(din[7]),
    .din_8(din[8]),   .din_9(din[9]),   .din_10(din[10]), .din_11(din[11]),
    .din_12(din[12]), .din_13(din[13]), .din_14(din[14]), .din_15(din[15]),
    .dout_valid(dout_valid),
    .a1_0(a1[0]), .a1_1(a1[1]), .a1_2(a1[2]), .a1_3(a1[3]),
    .a1_4(a1[4]), .a1_5(a1[5]), .a1_6(a1[6]), .a1_7(a1[7])
  );

  localparam logic [31:0] H [8] = '{32'hbd9b2b0e, 32'hbcf2c635, 32'h3efec7e0, 32'h3f4dc1d3,
                                    32'h3e9880d1, 32'hbdcb339e, 32'hbc4e80df, 32'h3d03fc5f};
  localparam logic [31:0] One   = 32'h3f800000;
  localparam logic [31:0] Sqrt2 = 32'h3fb504f3;

  typedef logic [7:0][31:0] beat_out_t;
  typedef struct packed { logic v; beat_out_t d; } out_t;
  typedef struct packed {
    logic [15:0][31:0] b0;
    logic [15:0][31:0] b1;
    beat_out_t         e0;
    beat_out_t         e1;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] xs  [$];  // every accepted sample since reset, oldest first
  out_t        dl  [$];
  out_t        cur;
  beat_out_t   obs [$];

  task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ulp(input string name, input logic [31:0] act, input logic [31:0] exp);
    int diff;
    checks++;
    diff = (act > exp) ? int'(act - exp) : int'(exp - act);
    if (act[31] != exp[31] || diff > 2) begin
      errors++;
      $display("FAIL %s: got %h expected %h within 2 ulp", name, act, exp);
    end
  endtask

  function automatic real f2r(logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'd0) return 0.0;
    b[63]    = f[31];
    b[62:52] = (f[30:23] == 8'hff) ? 11'h7ff : 11'(f[30:23]) + 11'd896;
    b[51:0]  = {f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  // Double to FP32, nearest-even, subnormal results flushed to +0.
  function automatic logic [31:0] r2f(real r);
    logic [63:0] b;
    logic [23:0] m;
    int          e;
    b = $realtobits(r);
    if (b[62:52] == 11'h7ff) return (b[51:0] != 52'd0) ? 32'h7fc00000 : {b[63], 8'hff, 23'd0};
    if (b[62:52] == 11'd0) return {b[63] & (b[51:0] == 52'd0), 31'd0};
    e = int'(b[62:52]) - 1023;
    if (e < -126) return 32'h0;
    m = {1'b0, b[51:29]} + 24'(b[28] & ((|b[27:0]) | b[29]));
    if (m[23]) e++;
    if (e > 127) return {b[63], 8'hff, 23'd0};
    return {b[63], 8'(e + 127), m[22:0]};
  endfunction

  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // a[m] = sum_j H_j * x[2m+1-j] over the global sample stream, for the newest beat.
  function automatic beat_out_t ref_beat();
    beat_out_t   r;
    logic [31:0] p [8];
    int          b, m, idx;
    b = xs.size() / 16 - 1;
    for (int k = 0; k < 8; k++) begin
      m = 8 * b + k;
      for (int j = 0; j < 8; j++) begin
        idx  = 2 * m + 1 - j;
        p[j] = fmul(H[j], (idx < 0) ? 32'h0 : xs[idx]);
      end
      r[k] = fadd(fadd(fadd(p[0], p[1]), fadd(p[2], p[3])),
                  fadd(fadd(p[4], p[5]), fadd(p[6], p[7])));
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_f();
    if ($urandom_range(0, 15) == 0) return 32'h0;
    return {1'($urandom), 8'(117 + $urandom_range(0, 20)), 23'($urandom)};
  endfunction

  function automatic logic [15:0][31:0] rand_beat();
    logic [15:0][31:0] r;
    for (int i = 0; i < 16; i++) r[i] = rand_f();
    return r;
  endfunction

  task automatic model_clear();
    xs.delete();
    dl.delete();
    repeat (5) dl.push_back('0);
    cur = '0;
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear immediately.
  task automatic do_reset();
    #2;
    rstn      = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    model_clear();
    #1;
    chk("reset_outputs", {dout_valid, a1}, '0);
    @(negedge clk_78_125);
    @(negedge clk_78_125);
    rstn = 1'b1;
  endtask

  task automatic step(input logic v, input logic [15:0][31:0] d);
    out_t e;
    @(negedge clk_78_125);
    chk("cycle_output", {dout_valid, a1}, cur);
    if (dout_valid) obs.push_back(a1);
    din_valid = v;
    din       = d;
    e         = '0;
    if (v) begin
      for (int i = 0; i < 16; i++) xs.push_back(d[i]);
      e.v = 1'b1;
      e.d = ref_beat();
    end
    dl.push_back(e);
    @(posedge clk_78_125);
    e = dl.pop_front();
    if (e.v) cur = e;
    else cur.v = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic rst, input string tag);
    if (rst) do_reset();
    obs.delete();
    step(1'b1, v.b0);
    step(1'b1, v.b1);
    repeat (7) step(1'b0, '0);
    chk({tag, "_count"}, obs.size(), 2);
    if (obs.size() >= 2) begin
      chk({tag, "_beat0"}, obs[0], v.e0);
      chk({tag, "_beat1"}, obs[1], v.e1);
    end
  endtask

  initial begin
    vec_t              tbl [3];
    logic [15:0][31:0] rb  [12];
    logic [15:0][31:0] ones;
    beat_out_t         ref_obs [$];
    int                lat;

    tbl[0] = '0;
    tbl[1] = '0;
    tbl[1].b0[0] = One;
    tbl[1].e0[0] = H[1]; tbl[1].e0[1] = H[3]; tbl[1].e0[2] = H[5]; tbl[1].e0[3] = H[7];
    tbl[2] = '0;
    tbl[2].b0[15] = One;
    tbl[2].e0[7] = H[0];
    tbl[2].e1[0] = H[2]; tbl[2].e1[1] = H[4]; tbl[2].e1[2] = H[6];
    for (int i = 0; i < 16; i++) ones[i] = One;

    do_reset();
    for (int t = 0; t < 3; t++) run_vec(tbl[t], 1'b1, $sformatf("vec%0d", t));

    // Latency: first valid output six negedges after the capture edge.
    do_reset();
    step(1'b1, '0);
    #1 din_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk_78_125);
      if (dout_valid) lat = i;
    end
    chk("latency", lat, 6);

    // DC input converges to sqrt2 once the history is full.
    do_reset();
    obs.delete();
    repeat (3) step(1'b1, ones);
    repeat (7) step(1'b0, '0);
    chk("dc_count", obs.size(), 3);
    if (obs.size() >= 3) begin
      chk("dc_b0_a0", obs[0][0], fadd(H[0], H[1]));
      for (int k = 3; k < 8; k++) chk_ulp($sformatf("dc_b0_a%0d", k), obs[0][k], Sqrt2);
      for (int k = 0; k < 8; k++) chk_ulp($sformatf("dc_b1_a%0d", k), obs[1][k], Sqrt2);
    end

    // Gapped stream must reproduce the gapless outputs; idle beats carry junk data.
    for (int i = 0; i < 12; i++) rb[i] = rand_beat();
    do_reset();
    obs.delete();
    for (int i = 0; i < 12; i++) step(1'b1, rb[i]);
    repeat (7) step(1'b0, '0);
    ref_obs = obs;
    do_reset();
    obs.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, rb[i]);
      repeat ($urandom_range(0, 3)) step(1'b0, rand_beat());
    end
    repeat (7) step(1'b0, '0);
    chk("gap_count", obs.size(), ref_obs.size());
    for (int i = 0; i < obs.size() && i < ref_obs.size(); i++)
      chk($sformatf("gap_beat%0d", i), obs[i], ref_obs[i]);

    // Random valid pattern against the model.
    do_reset();
    for (int i = 0; i < 150; i++) step($urandom_range(0, 9) < 7, rand_beat());

    // Mid-stream reset with beats in flight, then the impulse must come out clean.
    for (int i = 0; i < 8; i++) step(1'b1, rand_beat());
    do_reset();
    run_vec(tbl[1], 1'b0, "post_reset_impulse");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
